// File: rtl/keypad_matrix_emulator_if.sv
// keypad_matrix_emulator_if: key-code push handshake between a producer and the emulator.
interface keypad_matrix_emulator_if;
  logic [3:0] key_in;
  logic       key_valid;
  logic       key_ready;
  modport master (output key_in, key_valid, input key_ready);
  modport slave (input key_in, key_valid, output key_ready);
endinterface

// File: rtl/keypad_matrix_emulator.sv
// keypad_matrix_emulator: plays queued key codes onto 4x4 row/col lines with bounce, hold and release gap.
module keypad_matrix_emulator #(
  parameter int BOUNCE_CYCLES = 4,
  parameter int PRESS_CYCLES  = 16,
  parameter int GAP_CYCLES    = 8,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  keypad_matrix_emulator_if.slave  kif,
  output logic [3:0]               rows,
  output logic [3:0]               cols,
  output logic                     pressed,
  output logic                     busy
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int M1 = BOUNCE_CYCLES > PRESS_CYCLES ? BOUNCE_CYCLES : PRESS_CYCLES;
  localparam int MX = M1 > GAP_CYCLES ? M1 : GAP_CYCLES;
  localparam int CW = $clog2(MX + 1);
  localparam logic [1:0] IDLE = 2'd0, BOUNCE = 2'd1, HOLD = 2'd2, GAP = 2'd3;

  logic [3:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0]   count;
  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [3:0]    code;
  logic          push, pop, last, line_on;

  assign kif.key_ready = count != (AW+1)'(FIFO_DEPTH);
  assign push    = kif.key_valid & kif.key_ready;
  assign pop     = state == IDLE && count != '0;
  assign last    = state == BOUNCE ? cnt == CW'(BOUNCE_CYCLES - 1) :
                   state == HOLD   ? cnt == CW'(PRESS_CYCLES - 1) :
                                     cnt == CW'(GAP_CYCLES - 1);
  assign line_on = state == HOLD || (state == BOUNCE && !cnt[0]);
  assign pressed = |rows;
  assign busy    = count != '0 || state != IDLE;

  always_ff @(posedge clk)
    if (push) mem[wp] <= kif.key_in;

  // Lines are registered from the current state, so they trail the FSM by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
      state <= IDLE;
      cnt   <= '0;
      code  <= '0;
      rows  <= '0;
      cols  <= '0;
    end else begin
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      rows <= line_on ? 4'b0001 << code[3:2] : 4'b0000;
      cols <= line_on ? 4'b0001 << code[1:0] : 4'b0000;
      if (state == IDLE) begin
        if (pop) begin
          code  <= mem[rp];
          cnt   <= '0;
          state <= BOUNCE_CYCLES == 0 ? HOLD : BOUNCE;
        end
      end else begin
        cnt <= last ? '0 : cnt + 1'b1;
        if (last) state <= state == GAP ? IDLE : state + 2'd1;
      end
    end
  end
endmodule

// File: tb/tb_keypad_matrix_emulator.sv
// tb_keypad_matrix_emulator: scoreboard bench; accepted codes are queued and matched against played line timelines.
module tb_keypad_matrix_emulator;
  localparam int B = 4, P = 16, G = 8, T = B + P + G;
  logic clk = 0, rst_n = 0;
  always #5 clk = ~clk;
  keypad_matrix_emulator_if kif ();
  keypad_matrix_emulator_if kif2 ();
  logic [3:0] rows, cols, rows2, cols2;
  logic pressed, busy, pressed2, busy2;
  keypad_matrix_emulator dut (.clk(clk), .rst_n(rst_n), .kif(kif), .rows(rows), .cols(cols),
                              .pressed(pressed), .busy(busy));
  keypad_matrix_emulator #(.BOUNCE_CYCLES(0)) dut0 (.clk(clk), .rst_n(rst_n), .kif(kif2), .rows(rows2),
                              .cols(cols2), .pressed(pressed2), .busy(busy2));

  int checks = 0, errors = 0;
  logic [3:0] sb [$];
  bit mon_active = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [3:0] c);
    @(negedge clk);
    kif.key_in = c;
    kif.key_valid = 1;
    for (int i = 0; i < 200 && !kif.key_ready; i++) @(negedge clk);
    if (!kif.key_ready) begin
      chk("send_timeout", 32'(kif.key_ready), 1);
      kif.key_valid = 0;
    end else begin
      sb.push_back(c);
      @(posedge clk);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    kif.key_valid = 0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !busy && !mon_active) return;
    end
    chk("drain_timeout", 32'(busy), 0);
  endtask

  // Line monitor: every press must replay the oldest accepted code with the exact bounce/hold/gap shape.
  initial begin
    logic [3:0] e;
    bit on, aborted;
    forever begin
      @(negedge clk);
      if (rst_n && pressed) begin
        mon_active = 1;
        aborted = 0;
        if (sb.size() == 0) begin
          chk("spurious_press", 32'(pressed), 0);
          e = 4'h0;
        end else e = sb.pop_front();
        for (int k = 0; k < T; k++) begin
          if (k > 0) @(negedge clk);
          if (!rst_n) begin
            aborted = 1;
            sb.delete();
            break;
          end
          on = k < B ? (k % 2 == 0) : (k < B + P);
          chk($sformatf("rows k%0d code%0h", k, e), 32'(rows), on ? 32'(4'b0001 << e[3:2]) : 0);
          chk($sformatf("cols k%0d code%0h", k, e), 32'(cols), on ? 32'(4'b0001 << e[1:0]) : 0);
          chk($sformatf("pressed k%0d", k), 32'(pressed), 32'(on));
        end
        if (!aborted) begin
          @(negedge clk);
          chk("idle_slot", 32'(pressed), 0);
        end
        mon_active = 0;
      end
    end
  end

  initial begin
    #200us;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    kif.key_in = 0;
    kif.key_valid = 0;
    kif2.key_in = 0;
    kif2.key_valid = 0;
    #1;
    chk("rst_rows", 32'(rows), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ready", 32'(kif.key_ready), 1);
    repeat (3) @(negedge clk);
    rst_n = 1;
    // reset mid-HOLD
    send(4'h6);
    idle();
    repeat (B + 4) @(negedge clk);
    chk("pre_rst_pressed", 32'(pressed), 1);
    #2 rst_n = 0;
    #1;
    chk("async_rows", 32'(rows), 0);
    chk("async_cols", 32'(cols), 0);
    chk("async_pressed", 32'(pressed), 0);
    chk("async_busy", 32'(busy), 0);
    chk("async_ready", 32'(kif.key_ready), 1);
    repeat (2) @(negedge clk);
    rst_n = 1;
    repeat (40) @(negedge clk);
    chk("post_rst_pressed", 32'(pressed), 0);
    chk("post_rst_busy", 32'(busy), 0);
    // single key with latency
    send(4'h9);
    idle();
    chk("lat_n0", 32'(pressed), 0);
    @(negedge clk);
    chk("lat_n1", 32'(pressed), 0);
    @(negedge clk);
    chk("lat_n2", 32'(pressed), 1);
    chk("lat_rows", 32'(rows), 32'(4'b0100));
    chk("lat_cols", 32'(cols), 32'(4'b0010));
    wait_done(200);
    // six back-to-back keys, queue fills
    for (int i = 0; i < 5; i++) send(4'(i));
    #1 chk("q_full_ready", 32'(kif.key_ready), 0);
    send(4'h5);
    idle();
    wait_done(1000);
    // valid held while full with changing codes: dropped codes never appear
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      kif.key_in = 4'((i * 7 + 3) % 16);
      kif.key_valid = 1;
      if (i == 5) chk("hold_full_ready", 32'(kif.key_ready), 0);
      if (kif.key_ready) sb.push_back(kif.key_in);
    end
    idle();
    wait_done(2000);
    // all 16 codes decode back to themselves
    for (int i = 0; i < 16; i++) send(4'(i));
    idle();
    wait_done(2000);
    // no-bounce instance
    @(negedge clk);
    kif2.key_in = 4'hF;
    kif2.key_valid = 1;
    @(posedge clk);
    @(negedge clk);
    kif2.key_valid = 0;
    chk("nb_lat0", 32'(pressed2), 0);
    @(negedge clk);
    chk("nb_lat1", 32'(pressed2), 0);
    for (int k = 0; k < P + G; k++) begin
      @(negedge clk);
      chk($sformatf("nb_rows k%0d", k), 32'(rows2), k < P ? 32'(4'b1000) : 0);
      chk($sformatf("nb_cols k%0d", k), 32'(cols2), k < P ? 32'(4'b1000) : 0);
    end
    @(negedge clk);
    chk("nb_busy_end", 32'(busy2), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
